i2c_target_byte: RTL
====================

// Module: i2c_target_byte
// PURPOSE
//  Byte/transaction layer directly downstream of the I2C target bit MAC. Consumes per-bit RX strobes
//  and START/STOP, assembles bytes, matches the 7-bit address, and issues ACK/NACK and read-data bits
//  back to the MAC's TX bit queue. Presents a byte stream (valid/ready) to the application logic.
// PARAMETERS
//  I2C_ADDR  7'h42  target address (7-bit) this block responds to
// PORTS
//  clk                 in   1  system clock; must be at least 8x SCL
//  rst_n               in   1  synchronous, active-low reset
//  i2c_rx_bit_data_i   in   1  SDA sample from MAC, valid with i2c_rx_bit_valid_i
//  i2c_rx_bit_valid_i  in   1  1-cycle pulse per SCL rising edge
//  i2c_bus_start_i     in   1  START / repeated-START pulse from MAC
//  i2c_bus_stop_i      in   1  STOP pulse from MAC
//  i2c_tx_bit_data_o   out  1  next bit the MAC drives after the next SCL fall; 1 = release, 0 = pull low
//  i2c_tx_bit_valid_o  out  1  1-cycle strobe loading i2c_tx_bit_data_o into the MAC
//  rx_data_o           out  8  received write byte, MSB first on the wire
//  rx_valid_o          out  1  1-cycle pulse, rx_data_o valid
//  rx_ready_i          in   1  app can accept a byte; sampled on the byte-complete cycle
//  tx_data_i           in   8  read byte offered by the app
//  tx_valid_i          in   1  tx_data_i valid
//  tx_ready_o          out  1  1-byte TX holding register empty; transfer on tx_valid_i && tx_ready_o
//  tx_underrun_o       out  1  1-cycle pulse: read byte started with the holding register empty
//  addressed_o         out  1  level: current transaction is addressed to this target
//  rw_o                out  1  level: R/W bit of the current transaction (1 = read)
// BEHAVIOUR
//  Reset values: all outputs 0, except tx_ready_o = 1. State = IDLE, bit counter = 0, holding register empty.
//  States: IDLE, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK, IGNORE. bitcnt 0..7 counts rx_bit_valid_i.
//  - i2c_bus_start_i in any state: -> ADDR, bitcnt = 0, addressed_o = 0. Has priority over same-cycle rx bit.
//  - i2c_bus_stop_i in any state: -> IDLE, addressed_o = 0. Holding register is kept.
//  - ADDR: shift bits MSB first. On the 8th bit, compare [7:1] with I2C_ADDR.
//    Match: rw_o = bit0, addressed_o = 1, emit tx bit 0 (ACK) -> ADDR_ACK.
//    No match: emit nothing -> IGNORE.
//  - ADDR_ACK: on the 9th bit, if rw_o = 1 load the holding register into the shifter and emit its MSB -> READ.
//    Otherwise -> WRITE.
//  - WRITE: on the 8th bit, if rx_ready_i: rx_data_o = byte, rx_valid_o pulse, emit 0 (ACK) -> WR_ACK.
//    Else: byte is dropped, emit 1 (NACK) -> IGNORE.
//  - WR_ACK: on the 9th bit -> WRITE, bitcnt = 0.
//  - READ: on bits 1..7, emit shifter bit 6..0. On the 8th bit, emit 1 (release for the controller's ACK) -> RD_ACK.
//  - RD_ACK: on the 9th bit, a sampled 0 (controller ACK) loads the next byte, emits its MSB -> READ.
//    A sampled 1 (NACK) -> IGNORE.
//  - IGNORE: no tx strobes; wait for START/STOP.
//  Loading a read byte from an empty holding register: shifter = 8'hFF, tx_underrun_o pulses.
//  Loading clears the holding register (tx_ready_o = 1 next cycle). tx_valid_i on that same cycle is accepted after the load.
//  Latency: i2c_tx_bit_valid_o and rx_valid_o are registered, one cycle after the triggering i2c_rx_bit_valid_i.
//  Every emitted tx bit therefore reaches the MAC well before the following SCL fall.
//  After a MAC-driven bit, the MAC itself returns SDA to release; no explicit release strobe is needed.
//  Reset mid-transaction: immediate return to reset values; the in-flight byte is lost.
// CONFIGURATION
//  I2C_TARGET_GENERAL_CALL_EN defined: address byte 8'h00 (general call, write) is also ACKed.
//    addressed_o = 1, rw_o = 0, then proceeds as WRITE.
//  Undefined: 8'h00 is treated as a non-matching address -> IGNORE.
// TESTING
//  1. START, 8'h84 (0x42 W), 8'hA5, STOP -> ACK (tx 0) after each byte, rx_data_o = 8'hA5 one pulse; addressed_o falls at STOP.
//  2. START, 8'h86 (0x43 W) -> no i2c_tx_bit_valid_o, addressed_o = 0, state IGNORE until STOP.
//  3. Preload 8'h3C, START, 8'h85, ctrl ACK, app loads 8'h81, ctrl NACK -> wire bytes 3C then 81; no underrun.
//  4. START, 8'h85, holding register empty -> wire byte FF, tx_underrun_o = 1 pulse.
//  5. Write with rx_ready_i = 0 at byte 1 -> NACK (tx 1), no rx_valid_o. Repeated START, 8'h84 -> ACK again.
//  6. START, 8'h00 -> ACK with I2C_TARGET_GENERAL_CALL_EN, no ACK without it. rst_n low mid-byte -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/i2c_target_byte.sv
// Byte/transaction layer for an I2C target: address match, ACK/NACK generation, write byte
// stream out and read byte stream in. Define I2C_TARGET_GENERAL_CALL_EN to also ACK address 8'h00.
module i2c_target_byte #(
  parameter logic [6:0] I2C_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i2c_rx_bit_data_i,
  input  logic       i2c_rx_bit_valid_i,
  input  logic       i2c_bus_start_i,
  input  logic       i2c_bus_stop_i,
  output logic       i2c_tx_bit_data_o,
  output logic       i2c_tx_bit_valid_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_underrun_o,
  output logic       addressed_o,
  output logic       rw_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK, IGNORE
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        addressed_q, addressed_d;
  logic        rw_q, rw_d;
  logic        hold_full_q, hold_full_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic        tx_bit_data_q, tx_bit_data_d;
  logic        tx_bit_valid_q, tx_bit_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        underrun_q, underrun_d;

  logic [7:0]  rx_byte;
  logic [7:0]  load_byte;
  logic        addr_match;
  logic        gc_match;
  logic        load;

  assign rx_byte    = {shift_q[6:0], i2c_rx_bit_data_i};
  assign addr_match = (rx_byte[7:1] == I2C_ADDR);
  assign load_byte  = hold_full_q ? hold_data_q : 8'hFF;

`ifdef I2C_TARGET_GENERAL_CALL_EN
  assign gc_match = (rx_byte == 8'h00);
`else
  assign gc_match = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    bitcnt_d       = bitcnt_q;
    shift_d        = shift_q;
    addressed_d    = addressed_q;
    rw_d           = rw_q;
    hold_full_d    = hold_full_q;
    hold_data_d    = hold_data_q;
    tx_bit_data_d  = tx_bit_data_q;
    tx_bit_valid_d = 1'b0;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    underrun_d     = 1'b0;
    load           = 1'b0;

    if (i2c_bus_start_i) begin
      state_d     = ADDR;
      bitcnt_d    = 3'd0;
      addressed_d = 1'b0;
    end else if (i2c_bus_stop_i) begin
      state_d     = IDLE;
      addressed_d = 1'b0;
    end else if (i2c_rx_bit_valid_i) begin
      unique case (state_q)
        ADDR: begin
          shift_d  = rx_byte;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            if (addr_match || gc_match) begin
              addressed_d    = 1'b1;
              rw_d           = rx_byte[0];
              tx_bit_data_d  = 1'b0;
              tx_bit_valid_d = 1'b1;
              state_d        = ADDR_ACK;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          bitcnt_d = 3'd0;
          if (rw_q) begin
            load    = 1'b1;
            state_d = READ;
          end else begin
            state_d = WRITE;
          end
        end
        WRITE: begin
          shift_d  = rx_byte;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            tx_bit_valid_d = 1'b1;
            if (rx_ready_i) begin
              rx_data_d     = rx_byte;
              rx_valid_d    = 1'b1;
              tx_bit_data_d = 1'b0;
              state_d       = WR_ACK;
            end else begin
              tx_bit_data_d = 1'b1;
              state_d       = IGNORE;
            end
          end
        end
        WR_ACK: begin
          bitcnt_d = 3'd0;
          state_d  = WRITE;
        end
        READ: begin
          tx_bit_valid_d = 1'b1;
          if (bitcnt_q == 3'd7) begin
            tx_bit_data_d = 1'b1;
            bitcnt_d      = 3'd0;
            state_d       = RD_ACK;
          end else begin
            // Shifter MSB is already on the wire; bit 6 is the next one out.
            tx_bit_data_d = shift_q[6];
            shift_d       = {shift_q[6:0], 1'b1};
            bitcnt_d      = bitcnt_q + 3'd1;
          end
        end
        RD_ACK: begin
          bitcnt_d = 3'd0;
          if (!i2c_rx_bit_data_i) begin
            load    = 1'b1;
            state_d = READ;
          end else begin
            state_d = IGNORE;
          end
        end
        default: ;
      endcase
    end

    if (load) begin
      shift_d        = load_byte;
      underrun_d     = !hold_full_q;
      hold_full_d    = 1'b0;
      tx_bit_data_d  = load_byte[7];
      tx_bit_valid_d = 1'b1;
    end

    // The app handshake uses the pre-load ready, so a byte offered on a load cycle lands after it.
    if (tx_valid_i && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_data_d = tx_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      bitcnt_q       <= 3'd0;
      shift_q        <= 8'h00;
      addressed_q    <= 1'b0;
      rw_q           <= 1'b0;
      hold_full_q    <= 1'b0;
      hold_data_q    <= 8'h00;
      tx_bit_data_q  <= 1'b0;
      tx_bit_valid_q <= 1'b0;
      rx_data_q      <= 8'h00;
      rx_valid_q     <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      bitcnt_q       <= bitcnt_d;
      shift_q        <= shift_d;
      addressed_q    <= addressed_d;
      rw_q           <= rw_d;
      hold_full_q    <= hold_full_d;
      hold_data_q    <= hold_data_d;
      tx_bit_data_q  <= tx_bit_data_d;
      tx_bit_valid_q <= tx_bit_valid_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      underrun_q     <= underrun_d;
    end
  end

  assign i2c_tx_bit_data_o  = tx_bit_data_q;
  assign i2c_tx_bit_valid_o = tx_bit_valid_q;
  assign rx_data_o          = rx_data_q;
  assign rx_valid_o         = rx_valid_q;
  assign tx_ready_o         = !hold_full_q;
  assign tx_underrun_o      = underrun_q;
  assign addressed_o        = addressed_q;
  assign rw_o               = rw_q;

endmodule
